// File: rtl/mor1kx_bus_if_wbn_pkg.sv
// Shared mor1kx bus-interface definitions: FSM states and Wishbone CTI/BTE codes.
package mor1kx_bus_if_wbn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_BURST,
        ST_RETRY_WAIT,
        ST_DONE
    } state_t;

    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_INC_BURST = 3'b010;
    localparam logic [2:0] CTI_END_BURST = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    function automatic logic [1:0] bte_for(input int unsigned beats);
        case (beats)
            4:       return BTE_WRAP4;
            16:      return BTE_WRAP16;
            default: return BTE_WRAP8;
        endcase
    endfunction

endpackage

// File: rtl/mor1kx_wb_burst_addr.sv
// Wrapping beat-address generator: word-aligns the address and optionally steps
// the in-burst word index modulo BURST_LENGTH, holding the upper bits.
module mor1kx_wb_burst_addr #(
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LENGTH = 8
) (
    input  logic [31:0] start_adr,
    input  logic        inc,
    output logic [31:0] beat_adr
);

    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam int IW  = $clog2(BURST_LENGTH);

    logic [IW-1:0] idx;

    always_comb begin
        idx                = start_adr[LSB +: IW] + IW'(inc);
        beat_adr           = start_adr;
        beat_adr[LSB +: IW] = idx;
        beat_adr[LSB-1:0]  = '0;
    end

endmodule

// File: rtl/mor1kx_bus_if_wbn.sv
// CPU-to-Wishbone B3 bridge: single accesses and wrapping read bursts with
// retry, timeout and error handling; all Wishbone outputs are registered.
module mor1kx_bus_if_wbn
    import mor1kx_bus_if_wbn_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SEL_WIDTH    = DATA_WIDTH / 8,
    parameter int BURST_LENGTH = 8,
    parameter int MAX_RETRY    = 3,
    parameter int RETRY_DELAY  = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic [31:0]           cpu_adr_i,
    input  logic                  cpu_we_i,
    input  logic                  cpu_burst_i,
    input  logic [SEL_WIDTH-1:0]  cpu_bsel_i,
    input  logic [DATA_WIDTH-1:0] cpu_dat_i,
    output logic                  cpu_ack_o,
    output logic                  cpu_err_o,
    output logic [DATA_WIDTH-1:0] cpu_dat_o,
    output logic                  cpu_last_o,
    output logic [31:0]           wbm_adr_o,
    output logic [DATA_WIDTH-1:0] wbm_dat_o,
    output logic [SEL_WIDTH-1:0]  wbm_sel_o,
    output logic                  wbm_we_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic [2:0]            wbm_cti_o,
    output logic [1:0]            wbm_bte_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic                  wbm_rty_i,
    input  logic [DATA_WIDTH-1:0] wbm_dat_i
);

    localparam int BW = $clog2(BURST_LENGTH) + 1;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int WW = $clog2(RETRY_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, next_state;
    logic [BW-1:0] beat_cnt;
    logic [RW-1:0] retry_cnt;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] tmo_cnt;

    logic        active, launch, start_burst, rty_exhausted, timeout_hit;
    logic        fail, retry, beat_ack, last_beat, wait_done;
    logic [31:0] addr_src, beat_adr;

    mor1kx_wb_burst_addr #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BURST_LENGTH (BURST_LENGTH)
    ) u_burst_addr (
        .start_adr (addr_src),
        .inc       (state != ST_IDLE),
        .beat_adr  (beat_adr)
    );

    assign addr_src = (state == ST_IDLE) ? cpu_adr_i : wbm_adr_o;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Bus-event decode; priority is err > rty > ack, timeout only when the slave is silent.
    always_comb begin
        active        = (state == ST_SINGLE) || (state == ST_BURST);
        launch        = (state == ST_IDLE) && cpu_req_i;
        start_burst   = !cpu_we_i && cpu_burst_i;
        rty_exhausted = retry_cnt == RW'(MAX_RETRY);
        timeout_hit   = (tmo_cnt == TW'(TIMEOUT)) && !wbm_ack_i && !wbm_rty_i;
        fail          = active && (wbm_err_i || (wbm_rty_i && rty_exhausted) || timeout_hit);
        retry         = active && !wbm_err_i && wbm_rty_i && !rty_exhausted;
        beat_ack      = active && wbm_ack_i && !wbm_err_i && !wbm_rty_i;
        last_beat     = (state == ST_SINGLE) || (beat_cnt == BW'(BURST_LENGTH - 1)) ||
                        (wbm_cti_o == CTI_END_BURST) || !cpu_req_i;
        wait_done     = (state == ST_RETRY_WAIT) && (wait_cnt == WW'(RETRY_DELAY - 1));
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:
                if (launch) next_state = start_burst ? ST_BURST : ST_SINGLE;
            ST_SINGLE, ST_BURST:
                if (fail)                       next_state = ST_DONE;
                else if (retry)                 next_state = ST_RETRY_WAIT;
                else if (beat_ack && last_beat) next_state = ST_DONE;
            ST_RETRY_WAIT:
                if (wait_done) next_state = (wbm_bte_o != BTE_LINEAR) ? ST_BURST : ST_SINGLE;
            ST_DONE:
                next_state = ST_IDLE;
            default:
                next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ack_o  <= 1'b0;
            cpu_err_o  <= 1'b0;
            cpu_last_o <= 1'b0;
            cpu_dat_o  <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_cti_o  <= CTI_CLASSIC;
            wbm_bte_o  <= BTE_LINEAR;
            beat_cnt   <= '0;
            retry_cnt  <= '0;
            wait_cnt   <= '0;
            tmo_cnt    <= '0;
        end else begin
            cpu_ack_o  <= 1'b0;
            cpu_err_o  <= 1'b0;
            cpu_last_o <= 1'b0;

            if (launch) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cpu_we_i;
                wbm_dat_o <= cpu_dat_i;
                wbm_sel_o <= cpu_bsel_i;
                beat_cnt  <= '0;
                retry_cnt <= '0;
                tmo_cnt   <= '0;
                if (start_burst) begin
                    wbm_adr_o <= beat_adr;
                    wbm_cti_o <= CTI_INC_BURST;
                    wbm_bte_o <= bte_for(BURST_LENGTH);
                end else begin
                    wbm_adr_o <= cpu_adr_i;
                    wbm_cti_o <= CTI_END_BURST;
                    wbm_bte_o <= BTE_LINEAR;
                end
            end

            if (fail) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                cpu_err_o <= 1'b1;
                cpu_dat_o <= '0;
            end else if (retry) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                retry_cnt <= retry_cnt + RW'(1);
                wait_cnt  <= '0;
            end else if (beat_ack) begin
                cpu_ack_o <= 1'b1;
                cpu_dat_o <= wbm_dat_i;
                tmo_cnt   <= '0;
                retry_cnt <= '0;
                beat_cnt  <= beat_cnt + BW'(1);
                if (last_beat) begin
                    cpu_last_o <= 1'b1;
                    wbm_cyc_o  <= 1'b0;
                    wbm_stb_o  <= 1'b0;
                end else begin
                    wbm_adr_o <= beat_adr;
                    if (beat_cnt == BW'(BURST_LENGTH - 2)) wbm_cti_o <= CTI_END_BURST;
                end
            end else if (active) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                // A withdrawn burst request turns the outstanding beat into the final one.
                if (state == ST_BURST && !cpu_req_i) wbm_cti_o <= CTI_END_BURST;
            end

            if (state == ST_RETRY_WAIT) begin
                if (wait_done) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    tmo_cnt   <= '0;
                end else begin
                    wait_cnt <= wait_cnt + WW'(1);
                end
            end

            if (state == ST_DONE) retry_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mor1kx_bus_if_wbn.sv
// Directed bench for mor1kx_bus_if_wbn: single, burst, retry, timeout, error and reset cases.
module tb_mor1kx_bus_if_wbn;
    import mor1kx_bus_if_wbn_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_i, cpu_we_i, cpu_burst_i;
    logic [31:0] cpu_adr_i, cpu_dat_i;
    logic [3:0]  cpu_bsel_i;
    logic        cpu_ack_o, cpu_err_o, cpu_last_o;
    logic [31:0] cpu_dat_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic [31:0] wbm_dat_i;

    int n_checks = 0, n_errors = 0;
    int ack_total = 0, err_total = 0, stb_total = 0, both_total = 0;
    int a0, e0, s0, gap, n;

    mor1kx_bus_if_wbn #(
        .DATA_WIDTH   (32),
        .BURST_LENGTH (8),
        .MAX_RETRY    (3),
        .RETRY_DELAY  (4),
        .TIMEOUT      (255)
    ) dut (
        .clk (clk), .rst (rst),
        .cpu_req_i (cpu_req_i), .cpu_adr_i (cpu_adr_i), .cpu_we_i (cpu_we_i),
        .cpu_burst_i (cpu_burst_i), .cpu_bsel_i (cpu_bsel_i), .cpu_dat_i (cpu_dat_i),
        .cpu_ack_o (cpu_ack_o), .cpu_err_o (cpu_err_o), .cpu_dat_o (cpu_dat_o),
        .cpu_last_o (cpu_last_o),
        .wbm_adr_o (wbm_adr_o), .wbm_dat_o (wbm_dat_o), .wbm_sel_o (wbm_sel_o),
        .wbm_we_o (wbm_we_o), .wbm_cyc_o (wbm_cyc_o), .wbm_stb_o (wbm_stb_o),
        .wbm_cti_o (wbm_cti_o), .wbm_bte_o (wbm_bte_o),
        .wbm_ack_i (wbm_ack_i), .wbm_err_i (wbm_err_i), .wbm_rty_i (wbm_rty_i),
        .wbm_dat_i (wbm_dat_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ack_total  += int'(cpu_ack_o);
        err_total  += int'(cpu_err_o);
        stb_total  += int'(wbm_stb_o);
        both_total += int'(cpu_ack_o & cpu_err_o);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic launch(input logic [31:0] adr, input logic we, input logic burst,
                          input logic [31:0] dat);
        cpu_adr_i   = adr;
        cpu_we_i    = we;
        cpu_burst_i = burst;
        cpu_dat_i   = dat;
        cpu_bsel_i  = 4'hF;
        cpu_req_i   = 1'b1;
        tick();
    endtask

    task automatic rty_gap(output int g);
        wbm_rty_i = 1'b1;
        tick();
        wbm_rty_i = 1'b0;
        g = 0;
        while (!wbm_cyc_o && g < 20) begin
            g++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_burst_i = 1'b0;
        cpu_adr_i = '0; cpu_dat_i = '0; cpu_bsel_i = '0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = '0;
        tick(); tick();
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_cti_bte", {wbm_cti_o, wbm_bte_o}, 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_cpu", {cpu_ack_o, cpu_err_o, cpu_last_o, cpu_dat_o}, 0);
        rst = 1'b0;
        tick();

        // single read, slave acks after two wait cycles
        a0 = ack_total;
        launch(32'h100, 1'b0, 1'b0, '0);
        check("single_cyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b110);
        check("single_adr", wbm_adr_o, 32'h100);
        check("single_cti", {wbm_cti_o, wbm_bte_o}, 5'b111_00);
        tick(); tick();
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEADBEEF;
        tick();
        wbm_ack_i = 1'b0;
        check("single_ack", {cpu_ack_o, cpu_last_o, cpu_err_o}, 3'b110);
        check("single_dat", cpu_dat_o, 32'hDEADBEEF);
        check("single_drop", wbm_cyc_o, 0);
        cpu_req_i = 1'b0;
        tick();
        check("single_pulse", cpu_ack_o, 0);
        check("single_nacks", ack_total - a0, 1);
        tick();

        // 8-beat wrapping burst from 0x1C, ack every cycle
        a0 = ack_total;
        launch(32'h1C, 1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) begin
            check("burst_adr", wbm_adr_o, (32'h1C + 32'(4 * i)) & 32'h1F);
            check("burst_cti", wbm_cti_o, (i == 7) ? 3'b111 : 3'b010);
            check("burst_bte", wbm_bte_o, 2'b10);
            if (i > 0) begin
                check("burst_dat", cpu_dat_o, 32'h1000 + 32'(i - 1));
                check("burst_mid_last", cpu_last_o, 0);
            end
            wbm_ack_i = 1'b1; wbm_dat_i = 32'h1000 + 32'(i);
            tick();
        end
        wbm_ack_i = 1'b0;
        check("burst_final", {cpu_ack_o, cpu_last_o, wbm_cyc_o}, 3'b110);
        check("burst_final_dat", cpu_dat_o, 32'h1007);
        cpu_req_i = 1'b0;
        tick();
        check("burst_nacks", ack_total - a0, 8);
        tick();

        // write retried twice then acked
        a0 = ack_total; e0 = err_total;
        launch(32'h200, 1'b1, 1'b0, 32'hCAFEF00D);
        check("wr_we", wbm_we_o, 1);
        check("wr_dat", wbm_dat_o, 32'hCAFEF00D);
        rty_gap(gap);
        check("wr_gap1", gap, 4);
        check("wr_readr", wbm_adr_o, 32'h200);
        rty_gap(gap);
        check("wr_gap2", gap, 4);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        check("wr_ack", {cpu_ack_o, cpu_err_o}, 2'b10);
        cpu_req_i = 1'b0;
        tick();
        check("wr_nacks", ack_total - a0, 1);
        check("wr_nerrs", err_total - e0, 0);
        tick();

        // four retries exhaust MAX_RETRY
        e0 = err_total;
        launch(32'h300, 1'b0, 1'b0, '0);
        repeat (3) rty_gap(gap);
        check("rty4_gap3", gap, 4);
        wbm_rty_i = 1'b1;
        tick();
        wbm_rty_i = 1'b0;
        check("rty4_err", {cpu_err_o, cpu_ack_o, wbm_cyc_o}, 3'b100);
        check("rty4_dat", cpu_dat_o, 0);
        cpu_req_i = 1'b0;
        tick();
        check("rty4_idle", dut.state, ST_IDLE);
        check("rty4_nerrs", err_total - e0, 1);
        tick();

        // silent slave times out
        launch(32'h400, 1'b0, 1'b0, '0);
        check("tmo_cyc", wbm_cyc_o, 1);
        n = 0;
        while (!cpu_err_o && n < 400) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 256);
        check("tmo_drop", wbm_cyc_o, 0);
        cpu_req_i = 1'b0;
        tick(); tick();

        // error on third burst beat
        a0 = ack_total; e0 = err_total;
        launch(32'h40, 1'b0, 1'b1, '0);
        wbm_ack_i = 1'b1;
        tick(); tick();
        wbm_ack_i = 1'b0; wbm_err_i = 1'b1;
        tick();
        wbm_err_i = 1'b0;
        check("berr_err", {cpu_err_o, cpu_ack_o, wbm_cyc_o, wbm_stb_o}, 4'b1000);
        check("berr_dat", cpu_dat_o, 0);
        cpu_req_i = 1'b0;
        s0 = stb_total;
        repeat (5) tick();
        check("berr_nostb", stb_total - s0, 0);
        check("berr_nacks", ack_total - a0, 2);
        check("berr_nerrs", err_total - e0, 1);

        // request withdrawn mid-burst
        a0 = ack_total;
        launch(32'h0, 1'b0, 1'b1, '0);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0; cpu_req_i = 1'b0;
        tick();
        check("wd_cti", {wbm_cti_o, wbm_cyc_o}, 4'b1111);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        check("wd_last", {cpu_ack_o, cpu_last_o, wbm_cyc_o}, 3'b110);
        tick(); tick();
        check("wd_nacks", ack_total - a0, 2);

        // reset mid-burst beats a concurrent ack
        launch(32'h80, 1'b0, 1'b1, '0);
        wbm_ack_i = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_bus", {wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o}, 0);
        check("rstmid_adr", wbm_adr_o, 0);
        check("rstmid_cpu", {cpu_ack_o, cpu_err_o, cpu_last_o, cpu_dat_o}, 0);
        rst = 1'b0; wbm_ack_i = 1'b0; cpu_req_i = 1'b0;
        tick();
        a0 = ack_total; e0 = err_total;
        repeat (4) tick();
        check("rstmid_quiet", (ack_total - a0) + (err_total - e0), 0);

        check("ack_err_excl", both_total, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
